prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader for the picoMIPS core: the writer on the program memory interface whose reader is the CPU fetch path. It accepts a byte stream over a valid/ready handshake, checks a framed image (sync, word count, instruction words, checksum), writes each assembled instruction into the program memory write port and holds the CPU in reset until a complete, checksum-correct image has been loaded.

## Interface
- INSTR_WIDTH, default 16: program memory word width; 9..32.
- ADDR_WIDTH, default 8: program memory address width; 1..8.
- SYNC_BYTE, default 8'hA5: frame start marker.
- BPW (localparam) = ceil(INSTR_WIDTH/8): bytes per instruction word.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  program memory write enable, one-cycle pulse.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  INSTR_WIDTH  write data.
- cpu_reset  out  1  active-high hold to the CPU program counter and core.
- done  out  1  valid image loaded; CPU running.
- error  out  1  last frame rejected.

## Operation
- Byte transfer: the rising edge on which in_valid && in_ready is high.
- Frame: SYNC_BYTE, count N (1..2^ADDR_WIDTH, with byte 0 meaning 256 only when ADDR_WIDTH = 8), N words of BPW bytes each (MSB first), checksum C. A frame is valid when the 8-bit sum of all word bytes plus C equals 0 mod 256. Sync and count bytes are excluded from the sum.
- Word assembly: left-shift by 8 per byte. The upper BPW*8-INSTR_WIDTH bits of the first byte are discarded.
- States:
  - IDLE: non-sync bytes are discarded. SYNC_BYTE goes to COUNT and clears error, done, sum and the address counter.
  - COUNT: a legal N is stored and the state goes to DATA. An illegal N (0 when ADDR_WIDTH < 8, or N > 2^ADDR_WIDTH) goes to ERROR.
  - DATA: accumulates bytes. Acceptance of the BPW-th byte goes to WRITE.
  - WRITE: one cycle with mem_we = 1. Next state is DATA if words remain, otherwise CHECK. mem_addr increments (wrapping) as WRITE exits.
  - CHECK: next byte is C. A valid frame goes to DONE, an invalid one to ERROR.
  - DONE: cpu_reset = 0 and done = 1. A SYNC_BYTE re-enters COUNT (reload) and reasserts cpu_reset. Other bytes are discarded.
  - ERROR: error = 1 and cpu_reset = 1. Behaves as IDLE for the next sync.
- in_ready = 0 only in WRITE; 1 in every other state.
- cpu_reset = 1 in every state except DONE.
- Memory is written before the checksum is verified. A rejected frame leaves partial contents, which is harmless because the CPU stays held.

## Timing
- Reset values (asynchronous, while reset_n = 0):
  - state = IDLE
  - in_ready = 1
  - mem_we = 0, mem_addr = 0, mem_wdata = 0
  - cpu_reset = 1, done = 0, error = 0
- All outputs are registered except in_ready, which is decoded from state.
- Last byte of word k accepted at edge t:
  - During cycle t..t+1: mem_we = 1, mem_addr = k, mem_wdata = word k.
  - in_ready = 0 for that one cycle.
  - Next byte is accepted no earlier than edge t+2.
- Checksum accepted at edge t: done/cpu_reset (or error) change at edge t, so they are visible from cycle t.
- Sync byte accepted in DONE at edge t: cpu_reset = 1 and done = 0 from cycle t.
- in_valid gaps of any length are allowed in every state. There is no timeout.
- Reset_n asserted mid-frame aborts immediately; no further mem_we. After release, the loader waits in IDLE for a new sync with cpu_reset = 1.
- Count wrap: the address counter wraps only after the final word, so N = 2^ADDR_WIDTH writes addresses 0..2^ADDR_WIDTH-1 exactly once.

## Test plan
- Single word (INSTR_WIDTH = 16): A5, 01, 12, 34, BA -> one mem_we with addr 0 and data 16'h1234. In the checksum-accept cycle, done = 1 and cpu_reset = 0.
- Three words with in_valid held high: A5, 03, 00 01, 00 02, 00 03, FA -> writes 0/0001, 1/0002, 2/0003. in_ready drops exactly one cycle after each word. done = 1.
- Bad checksum: same as the first case but with C = BB -> error = 1, cpu_reset stays 1, done = 0. A subsequent valid frame clears error and sets done.
- Garbage and illegal count: 00, FF, 5A before A5 -> ignored. With ADDR_WIDTH = 4, A5 00 and A5 11 -> error, no mem_we.
- Reload and random in_valid gaps: completed load, then A5 starts a second frame -> cpu_reset returns to 1 at the sync byte. Addresses restart at 0 and the data matches the reference model.
- Reset mid-frame: reset_n low after 2 of 4 data bytes -> all outputs at reset values, no further writes. A full frame after release loads correctly.

Source files
------------

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed boot image loader driving the picoMIPS program memory write port
module prog_loader #(
  parameter int         INSTR_WIDTH = 16,
  parameter int         ADDR_WIDTH  = 8,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   cpu_reset,
  output logic                   done,
  output logic                   error
);

  localparam int         BPW       = (INSTR_WIDTH + 7) / 8;
  localparam int         SW        = BPW * 8;
  localparam logic [8:0] MAX_N     = 9'(1 << ADDR_WIDTH);
  localparam logic [2:0] LAST_BYTE = 3'(BPW - 1);

  typedef enum logic [2:0] {
    IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERROR
  } state_t;

  state_t state, state_nxt;

  // shift holds the earlier bytes of the word being assembled; the top byte
  // of a full word is never needed again, so only SW-8 bits are kept
  logic [SW-9:0] shift;
  logic [SW-1:0] word_next;
  logic [2:0]    byte_cnt;
  logic [8:0]    words_left;
  logic [7:0]    sum;
  logic [7:0]    sum_plus;
  logic          take;
  logic          is_sync;
  logic          count_ok;
  logic          last_byte;

  assign take      = in_valid && in_ready;
  assign is_sync   = (in_data == SYNC_BYTE);
  assign word_next = {shift, in_data};
  assign sum_plus  = sum + in_data;
  assign last_byte = (byte_cnt == LAST_BYTE);
  // a zero count only means 2^8 words when the address space is that large
  assign count_ok  = ((in_data != 8'd0) || (ADDR_WIDTH == 8)) && ({1'b0, in_data} <= MAX_N);

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ERROR, DONE: if (take && is_sync) state_nxt = COUNT;
      COUNT:             if (take) state_nxt = count_ok ? DATA : ERROR;
      DATA:              if (take && last_byte) state_nxt = WRITE;
      WRITE:             state_nxt = (words_left == 9'd0) ? CHECK : DATA;
      CHECK:             if (take) state_nxt = (sum_plus == 8'd0) ? DONE : ERROR;
      default:           state_nxt = IDLE;
    endcase
  end

  // the only unregistered output: back-pressure during the write cycle
  always_comb begin
    in_ready = (state != WRITE);
  end

  // registered outputs and frame datapath (word assembly, checksum, address)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      shift      <= '0;
      byte_cnt   <= 3'd0;
      words_left <= 9'd0;
      sum        <= 8'd0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, ERROR, DONE: begin
          if (take && is_sync) begin
            error     <= 1'b0;
            done      <= 1'b0;
            cpu_reset <= 1'b1;
            sum       <= 8'd0;
            mem_addr  <= '0;
            byte_cnt  <= 3'd0;
          end
        end
        COUNT: begin
          if (take) begin
            if (count_ok) words_left <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            else          error      <= 1'b1;
          end
        end
        DATA: begin
          if (take) begin
            shift <= word_next[SW-9:0];
            sum   <= sum_plus;
            if (last_byte) begin
              byte_cnt   <= 3'd0;
              mem_we     <= 1'b1;
              mem_wdata  <= word_next[INSTR_WIDTH-1:0];
              words_left <= words_left - 9'd1;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        WRITE: mem_addr <= mem_addr + 1'b1;
        CHECK: begin
          if (take) begin
            if (sum_plus == 8'd0) begin
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed scoreboard bench for prog_loader
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int total = 0;
  int bad = 0;

  logic [19:0] sb[$];
  logic [15:0] words[$];

  always #5 clk = ~clk;

  prog_loader #(.INSTR_WIDTH(16), .ADDR_WIDTH(4), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // every write must match the oldest expected {addr,data}; an unexpected write compares against X
  always @(negedge clk) begin
    logic [31:0] exp;
    if (mem_we === 1'b1) begin
      exp = (sb.size() > 0) ? {12'd0, sb.pop_front()} : 32'bx;
      chk("mem_write", {12'd0, mem_addr, mem_wdata}, exp);
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    int g;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    g = 0;
    while (in_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) chk("ready_timeout", g, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] n, input bit corrupt, input int maxgap, input bit ready_chk);
    logic [7:0] s;
    logic [7:0] c;
    s = 8'd0;
    send(8'hA5, $urandom_range(0, maxgap));
    chk("sync_cpu_reset", cpu_reset, 1);
    chk("sync_done", done, 0);
    send(n, $urandom_range(0, maxgap));
    foreach (words[i]) begin
      send(words[i][15:8], $urandom_range(0, maxgap));
      sb.push_back({4'(i), words[i]});
      send(words[i][7:0], $urandom_range(0, maxgap));
      s = s + words[i][15:8] + words[i][7:0];
      if (ready_chk) begin
        chk("ready_drop", in_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_back", in_ready, 1);
      end
    end
    c = 8'd0 - s;
    if (corrupt) c = c + 8'd1;
    send(c, $urandom_range(0, maxgap));
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset_n = 1'b1;

    // garbage before sync is ignored
    send(8'h00, 0);
    send(8'hFF, 1);
    send(8'h5A, 0);
    chk("garbage_error", error, 0);
    chk("garbage_done", done, 0);
    chk("garbage_cpu_reset", cpu_reset, 1);

    // single word, literal frame bytes
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h12, 0);
    sb.push_back({4'd0, 16'h1234});
    send(8'h34, 0);
    send(8'hBA, 0);
    chk("t1_done", done, 1);
    chk("t1_cpu_reset", cpu_reset, 0);
    chk("t1_error", error, 0);

    // three words back to back, in_ready drops one cycle per word
    words = '{16'h0001, 16'h0002, 16'h0003};
    send_frame(8'd3, 1'b0, 0, 1'b1);
    chk("t2_done", done, 1);
    chk("t2_cpu_reset", cpu_reset, 0);

    // bad checksum, then recovery
    words = '{16'h1234};
    send_frame(8'd1, 1'b1, 0, 1'b0);
    chk("t3_error", error, 1);
    chk("t3_cpu_reset", cpu_reset, 1);
    chk("t3_done", done, 0);
    send_frame(8'd1, 1'b0, 1, 1'b0);
    chk("t3b_error", error, 0);
    chk("t3b_done", done, 1);

    // illegal counts 0 and 17 with a 4-bit address space
    send(8'hA5, 0);
    send(8'h00, 0);
    chk("t4_zero_error", error, 1);
    chk("t4_zero_cpu_reset", cpu_reset, 1);
    send(8'hA5, 2);
    chk("t4_sync_clears_error", error, 0);
    send(8'h11, 0);
    chk("t4_big_error", error, 1);
    chk("t4_big_done", done, 0);

    // full address space with random gaps, then a reload
    words.delete();
    for (int i = 0; i < 16; i++) words.push_back(16'($urandom));
    send_frame(8'd16, 1'b0, 3, 1'b0);
    chk("t5_full_done", done, 1);
    words.delete();
    for (int i = 0; i < 5; i++) words.push_back(16'($urandom));
    send_frame(8'd5, 1'b0, 3, 1'b0);
    chk("t5_reload_done", done, 1);
    chk("t5_reload_cpu_reset", cpu_reset, 0);

    // reset part-way through a two-word frame
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'hAA, 0);
    sb.push_back({4'd0, 16'hAABB});
    send(8'hBB, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_in_ready", in_ready, 1);
    chk("t6_mem_we", mem_we, 0);
    chk("t6_mem_addr", mem_addr, 0);
    chk("t6_mem_wdata", mem_wdata, 0);
    chk("t6_cpu_reset", cpu_reset, 1);
    chk("t6_done", done, 0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_wait_cpu_reset", cpu_reset, 1);
    chk("t6_wait_done", done, 0);
    words = '{16'hBEEF, 16'h0F0F};
    send_frame(8'd2, 1'b0, 2, 1'b0);
    chk("t6_done_after", done, 1);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
